// File: rtl/clock_step_ctrl.sv
// clock_step_ctrl: debounced run/halt/single-step sequencer driving the CPU clock enable.
// Define CLOCK_STEP_COUNT_EN to build the cpu_en cycle counter behind cycle_count.
//
// state      | meaning
// S_HALTED   | CPU stopped, waiting for RUN or a STEP press
// S_RUN      | free running, cpu_en high every cycle
// S_STEP     | one cpu_en cycle for an accepted STEP press
// S_HLT_LOCK | CPU executed HALT; held until the RUN switch is dropped
module clock_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_sw,
    input  logic        step_btn,
    input  logic        halt_req,
    output logic        cpu_en,
    output logic        running,
    output logic        halted,
    output logic [15:0] cycle_count
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {S_HALTED, S_RUN, S_STEP, S_HLT_LOCK} state_t;

    // index 0 = RUN switch, index 1 = STEP button
    logic [1:0]       raw;
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic             step_prev_q;
    logic             run_st, step_rise;
    state_t           state_q;

    assign raw = {step_btn, run_sw};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            stable_d[i] = stable_q[i];
            cnt_d[i]    = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            stable_q    <= '0;
            cnt_q[0]    <= '0;
            cnt_q[1]    <= '0;
            step_prev_q <= 1'b0;
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            stable_q    <= stable_d;
            cnt_q[0]    <= cnt_d[0];
            cnt_q[1]    <= cnt_d[1];
            step_prev_q <= stable_q[1];
        end
    end

    assign run_st    = stable_q[0];
    assign step_rise = stable_q[1] & ~step_prev_q;

    // A rise that lands outside S_HALTED is consumed here and never queued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_HALTED;
        end else begin
            case (state_q)
                S_HALTED: begin
                    if (run_st)         state_q <= S_RUN;
                    else if (step_rise) state_q <= S_STEP;
                end
                S_RUN: begin
                    if (halt_req)       state_q <= S_HLT_LOCK;
                    else if (!run_st)   state_q <= S_HALTED;
                end
                S_STEP:                 state_q <= S_HALTED;
                S_HLT_LOCK: begin
                    if (!run_st)        state_q <= S_HALTED;
                end
                default:                state_q <= S_HALTED;
            endcase
        end
    end

    assign cpu_en  = (state_q == S_RUN) || (state_q == S_STEP);
    assign running = (state_q == S_RUN);
    assign halted  = (state_q == S_HALTED) || (state_q == S_HLT_LOCK);

`ifdef CLOCK_STEP_COUNT_EN
    logic [15:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (cpu_en) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign cycle_count = count_q;
`else
    assign cycle_count = 16'h0000;
`endif

endmodule

// File: tb/tb_clock_step_ctrl.sv
// Bench for clock_step_ctrl: directed scenarios plus random front-panel traffic
// against a window-based debounce model and a mode-level sequencer model.
module tb_clock_step_ctrl;
    localparam int DC = 4;
    localparam int M_HALT = 0, M_RUN = 1, M_STEP = 2, M_LOCK = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run_sw = 1'b0, step_btn = 1'b0, halt_req = 1'b0;
    logic        cpu_en, running, halted;
    logic [15:0] cycle_count;
    int          n_cmp = 0, n_bad = 0;

    clock_step_ctrl #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .run_sw(run_sw), .step_btn(step_btn),
        .halt_req(halt_req), .cpu_en(cpu_en), .running(running),
        .halted(halted), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // Reference: raw samples kept per edge; a debounced value flips once the
    // last DC synchronized samples (two edges old) all disagree with it.
    bit          hist_run[$], hist_step[$];
    bit          m_run_st, m_step_st, m_step_prev;
    int          m_mode;
    logic [15:0] m_count;

    function automatic bit tap(input bit q[$], input int back);
        int idx;
        idx = q.size() - 1 - back;
        return (idx >= 0) ? q[idx] : 1'b0;
    endfunction

    function automatic bit accept(input bit q[$], input bit st);
        for (int j = 0; j < DC; j++)
            if (tap(q, j + 2) == st) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_reset();
        hist_run.delete(); hist_step.delete();
        m_run_st = 0; m_step_st = 0; m_step_prev = 0;
        m_mode = M_HALT; m_count = '0;
    endfunction

    function automatic void model_edge();
        bit rise;
        if (reset) return;
        rise = m_step_st && !m_step_prev;
        if (m_mode == M_RUN || m_mode == M_STEP) m_count = m_count + 16'd1;
        case (m_mode)
            M_HALT: m_mode = m_run_st ? M_RUN : (rise ? M_STEP : M_HALT);
            M_RUN:  m_mode = halt_req ? M_LOCK : (!m_run_st ? M_HALT : M_RUN);
            M_STEP: m_mode = M_HALT;
            default: m_mode = m_run_st ? M_LOCK : M_HALT;
        endcase
        m_step_prev = m_step_st;
        hist_run.push_back(run_sw);
        hist_step.push_back(step_btn);
        if (hist_run.size() > 16) void'(hist_run.pop_front());
        if (hist_step.size() > 16) void'(hist_step.pop_front());
        if (accept(hist_run, m_run_st)) m_run_st = !m_run_st;
        if (accept(hist_step, m_step_st)) m_step_st = !m_step_st;
    endfunction

    function automatic bit exp_en();
        return (m_mode == M_RUN) || (m_mode == M_STEP);
    endfunction

    function automatic bit exp_halted();
        return (m_mode == M_HALT) || (m_mode == M_LOCK);
    endfunction

    function automatic logic [15:0] exp_count();
`ifdef CLOCK_STEP_COUNT_EN
        return m_count;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        run_sw = 1; step_btn = 0; halt_req = 0; reset = 1;
        model_reset();
        repeat (3) tick();
        n_cmp++;
        if (cpu_en !== 1'b0 || halted !== 1'b1 || running !== 1'b0 || cycle_count !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_state: got en=%b halted=%b run=%b cnt=%h want 0 1 0 0000",
                     cpu_en, halted, running, cycle_count);
        end
        reset = 0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            n_cmp++;
            if (running !== (e == 7) || cpu_en !== (e == 7)) begin
                n_bad++;
                $display("FAIL reset_release edge %0d: got run=%b en=%b want %b", e, running, cpu_en, e == 7);
            end
        end
    endtask

    task automatic test_glitch();
        run_sw = 0;
        repeat (8) tick();
        n_cmp++;
        if (halted !== 1'b1) begin
            n_bad++; $display("FAIL glitch_setup: got halted=%b want 1", halted);
        end
        step_btn = 1;
        repeat (3) tick();
        step_btn = 0;
        repeat (12) begin
            tick();
            n_cmp++;
            if (cpu_en !== 1'b0 || cpu_en !== exp_en()) begin
                n_bad++; $display("FAIL glitch_cpu_en: got %b want 0", cpu_en);
            end
        end
        n_cmp++;
        if (cycle_count !== exp_count()) begin
            n_bad++; $display("FAIL glitch_count: got %h want %h", cycle_count, exp_count());
        end
    endtask

    task automatic test_step();
        int pulses = 0;
        logic [15:0] c0;
        c0 = cycle_count;
        for (int p = 0; p < 3; p++) begin
            step_btn = 1;
            repeat (50) begin
                tick();
                if (cpu_en) pulses++;
                n_cmp++;
                if (cpu_en !== exp_en()) begin
                    n_bad++; $display("FAIL step_cpu_en: got %b want %b", cpu_en, exp_en());
                end
            end
            step_btn = 0;
            repeat (50) begin
                tick();
                if (cpu_en) pulses++;
            end
        end
        n_cmp++;
        if (pulses != 3) begin
            n_bad++; $display("FAIL step_pulses: got %0d want 3", pulses);
        end
        n_cmp++;
        if (cycle_count !== exp_count()) begin
            n_bad++; $display("FAIL step_count: got %h want %h", cycle_count, exp_count());
        end
`ifdef CLOCK_STEP_COUNT_EN
        n_cmp++;
        if (cycle_count !== c0 + 16'd3) begin
            n_bad++; $display("FAIL step_count_delta: got %h want %h", cycle_count, c0 + 16'd3);
        end
`endif
    endtask

    task automatic test_halt_lock();
        int budget = 0;
        run_sw = 1;
        while (!running && budget < 20) begin tick(); budget++; end
        n_cmp++;
        if (!running) begin
            n_bad++; $display("FAIL halt_start_timeout: got running=%b want 1", running);
        end
        repeat (20) tick();
        halt_req = 1;
        tick();
        halt_req = 0;
        n_cmp++;
        if (cpu_en !== 1'b0 || halted !== 1'b1 || running !== 1'b0) begin
            n_bad++; $display("FAIL halt_lock: got en=%b halted=%b run=%b want 0 1 0", cpu_en, halted, running);
        end
        step_btn = 1; repeat (10) tick();
        step_btn = 0;
        repeat (10) begin
            tick();
            n_cmp++;
            if (cpu_en !== 1'b0) begin
                n_bad++; $display("FAIL lock_step_ignored: got en=%b want 0", cpu_en);
            end
        end
        run_sw = 0;
        repeat (7) tick();
        n_cmp++;
        if (halted !== 1'b1 || cpu_en !== 1'b0) begin
            n_bad++; $display("FAIL lock_release: got halted=%b en=%b want 1 0", halted, cpu_en);
        end
        run_sw = 1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            n_cmp++;
            if (running !== (e == 7)) begin
                n_bad++; $display("FAIL lock_resume edge %0d: got run=%b want %b", e, running, e == 7);
            end
        end
    endtask

    task automatic test_halt_and_fall();
        int budget = 0;
        run_sw = 0;
        while (m_run_st && budget < 20) begin tick(); budget++; end
        n_cmp++;
        if (running !== 1'b1) begin
            n_bad++; $display("FAIL fall_setup: got running=%b want 1", running);
        end
        halt_req = 1;
        tick();
        halt_req = 0;
        n_cmp++;
        if (halted !== 1'b1 || cpu_en !== 1'b0 || halted !== exp_halted()) begin
            n_bad++; $display("FAIL halt_fall_same_cycle: got halted=%b en=%b want 1 0", halted, cpu_en);
        end
        run_sw = 1; repeat (8) tick();
        step_btn = 1; repeat (30) tick();
        step_btn = 0; repeat (30) tick();
        run_sw = 0; repeat (8) tick();
        repeat (12) begin
            tick();
            n_cmp++;
            if (cpu_en !== 1'b0 || cpu_en !== exp_en()) begin
                n_bad++; $display("FAIL run_step_discarded: got en=%b want 0", cpu_en);
            end
        end
        n_cmp++;
        if (cycle_count !== exp_count()) begin
            n_bad++; $display("FAIL run_step_count: got %h want %h", cycle_count, exp_count());
        end
    endtask

    task automatic test_reset_midrun();
        run_sw = 1;
        repeat (10) tick();
        #3 reset = 1;
        model_reset();
        #1;
        n_cmp++;
        if (cpu_en !== 1'b0 || running !== 1'b0 || halted !== 1'b1 || cycle_count !== 16'h0) begin
            n_bad++; $display("FAIL midrun_reset: got en=%b run=%b halted=%b cnt=%h want 0 0 1 0000",
                              cpu_en, running, halted, cycle_count);
        end
        tick();
        reset = 0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            n_cmp++;
            if (cpu_en !== (e == 7)) begin
                n_bad++; $display("FAIL midrun_restart edge %0d: got en=%b want %b", e, cpu_en, e == 7);
            end
        end
    endtask

    task automatic test_random();
        int run_hold = 0, step_hold = 0;
        for (int c = 0; c < 1500; c++) begin
            if (run_hold == 0) begin run_sw = $urandom_range(0, 1); run_hold = $urandom_range(1, 60); end
            else run_hold--;
            if (step_hold == 0) begin step_btn = $urandom_range(0, 1); step_hold = $urandom_range(1, 12); end
            else step_hold--;
            halt_req = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 499) == 0) begin
                reset = 1; model_reset(); tick(); reset = 0;
            end
            tick();
            n_cmp++;
            if (cpu_en !== exp_en() || running !== (m_mode == M_RUN) ||
                halted !== exp_halted() || cycle_count !== exp_count()) begin
                n_bad++;
                $display("FAIL random cyc %0d: got en=%b run=%b halted=%b cnt=%h want %b %b %b %h",
                         c, cpu_en, running, halted, cycle_count,
                         exp_en(), m_mode == M_RUN, exp_halted(), exp_count());
            end
        end
        halt_req = 0;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_step();
        test_halt_lock();
        test_halt_and_fall();
        test_reset_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
